// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encoding, opcodes, control-field encodings and the decode dispatch for the multicycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       illegal_op;
    } ctrl_t;

    // Unrecognised opcodes fall back to FETCH, which doubles as the illegal test.
    function automatic state_t decode_next(logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_EXECUTE;
            OP_BEQ:       return S_BRANCH;
            OP_ADDI:      return S_ADDIEXEC;
            OP_J:         return S_JUMP;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state -> datapath control word decoder
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   op_legal,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PC_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb    = SRCB_IMMSH;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.illegal_op = ~op_legal;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JUMP: begin
                ctrl.pcsrc   = PC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS main control FSM with memory ready handshake
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           memwrite,
    output logic           iord,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           pcen,
    output logic           branch,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           illegal_op,
    output logic [STW-1:0] state_o
);

    state_t     state;
    ctrl_t      c;
    logic [5:0] op;
    logic       op_legal;

    assign op       = 6'(opcode);
    assign op_legal = decode_next(op) != S_FETCH;

    // Memory states hold until the access completes; encodings 13-15 recover to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            case (state)
                S_IDLE:     state <= S_FETCH;
                S_FETCH:    state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:   state <= decode_next(op);
                S_MEMADR:   state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:    state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:    state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXECUTE:  state <= S_ALUWB;
                S_ADDIEXEC: state <= S_ADDIWB;
                default:    state <= S_FETCH;
            endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .op_legal  (op_legal),
        .ctrl      (c)
    );

    assign mem_req    = c.mem_req;
    assign memwrite   = c.memwrite;
    assign iord       = c.iord;
    assign irwrite    = c.irwrite;
    assign pcwrite    = c.pcwrite;
    assign branch     = c.branch;
    assign pcen       = c.pcwrite | (c.branch & zero);
    assign regdst     = c.regdst;
    assign memtoreg   = c.memtoreg;
    assign regwrite   = c.regwrite;
    assign alusrca    = c.alusrca;
    assign alusrcb    = c.alusrcb;
    assign pcsrc      = c.pcsrc;
    assign aluop      = c.aluop;
    assign illegal_op = c.illegal_op;
    assign state_o    = STW'(state);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized and directed checks of mips_mc_ctrl against a path-based reference model
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcwrite, pcen, branch;
    logic       regdst, memtoreg, regwrite, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;
    int ms = 0;
    int path[$];
    logic [5:0] pool [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    logic [17:0] dut_v;

    mips_mc_ctrl #(.OPW(6), .STW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcen(pcen), .branch(branch), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dut_v = {mem_req, memwrite, iord, irwrite, pcwrite, pcen, branch, regdst,
                    memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Remaining states of each instruction after DECODE, one hex digit per state.
    function automatic int route(logic [5:0] op);
        case (op)
            6'h23:   return 'h345;
            6'h2b:   return 'h36;
            6'h00:   return 'h78;
            6'h04:   return 'h9;
            6'h08:   return 'hab;
            6'h02:   return 'hc;
            default: return 0;
        endcase
    endfunction

    function automatic logic [17:0] expv(int s, logic rdy, logic z, logic [5:0] op);
        logic mreq, mw, io, irw, pcw, br, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ps, ao;
        {mreq, mw, io, irw, pcw, br, rd, m2r, rw, sa, ill} = '0;
        {sb, ps, ao} = '0;
        case (s)
            1:  begin mreq = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
            2:  begin sb = 2'b11; ill = (route(op) == 0); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mreq = 1; io = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mreq = 1; mw = 1; io = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rd = 1; rw = 1; end
            9:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            12: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mreq, mw, io, irw, pcw, pcw | (br & z), br, rd, m2r, rw, sa, sb, ps, ao, ill};
    endfunction

    // Advance the model at a clock edge using the inputs held during the ending cycle.
    task automatic step();
        int r;
        if (!rst_n) begin
            ms = 0;
            path.delete();
        end else if (ms == 0)
            ms = 1;
        else if (!((ms == 1 || ms == 4 || ms == 6) && !mem_ready)) begin
            if (ms == 2) begin
                path.delete();
                r = route(opcode);
                while (r != 0) begin
                    path.push_front(r & 15);
                    r = r >> 4;
                end
            end
            ms = (ms == 1) ? 2 : (path.size() > 0 ? path.pop_front() : 1);
        end
    endtask

    always @(negedge clk) begin
        chk("state", int'(state_o), ms);
        chk("ctrl", int'(dut_v), int'(expv(ms, mem_ready, zero, opcode)));
    end

    task automatic cyc(input logic rdy, input logic z, input logic [5:0] op);
        @(posedge clk);
        step();
        #2 mem_ready = rdy;
        zero = z;
        opcode = op;
        @(negedge clk);
    endtask

    task automatic run_lat(input string nm, input logic [5:0] op, input int sig_exp, input int n_exp);
        int sig = 1;
        int n = 1;
        chk({nm, "_start"}, int'(state_o), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, op);
            if (state_o == 1) break;
            if (state_o == 5) chk("memwb", int'({regwrite, memtoreg, regdst}), 'b110);
            if (state_o == 7) chk("exec_aluop", int'(aluop), 2);
            if (state_o == 8) chk("aluwb", int'({regdst, regwrite}), 'b11);
            sig = sig * 16 + int'(state_o);
            n++;
        end
        chk({nm, "_seq"}, sig, sig_exp);
        chk({nm, "_lat"}, n, n_exp);
    endtask

    task automatic beq_t(input logic z);
        cyc(1, z, 6'h04);
        cyc(1, z, 6'h04);
        chk("beq_state", int'(state_o), 9);
        chk("beq_aluop_pcsrc", int'({aluop, pcsrc}), 'b0101);
        chk("beq_pcen", int'(pcen), int'(z));
        cyc(1, z, 6'h04);
        chk("beq_back", int'(state_o), 1);
    endtask

    initial begin
        cyc(0, 0, 6'h00);
        chk("rst_state", int'(state_o), 0);
        chk("rst_outs", int'(dut_v), 0);
        rst_n = 1'b1;
        cyc(1, 0, 6'h00);
        chk("rel_fetch", int'(state_o), 1);
        chk("rel_fetch_ctl", int'({mem_req, alusrcb}), 'b101);

        run_lat("lw", 6'h23, 'h12345, 5);
        run_lat("sw", 6'h2b, 'h1236, 4);
        run_lat("rtype", 6'h00, 'h1278, 4);
        run_lat("addi", 6'h08, 'h12ab, 4);
        run_lat("beq", 6'h04, 'h129, 3);
        run_lat("j", 6'h02, 'h12c, 3);

        beq_t(1);
        beq_t(0);

        cyc(1, 0, 6'h2b);
        cyc(1, 0, 6'h2b);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 0, 6'h2b);
            chk("stall_state", int'(state_o), 6);
            chk("stall_ctl", int'({mem_req, memwrite, iord}), 'b111);
        end
        cyc(1, 0, 6'h00);
        chk("stall_fetch", int'(state_o), 1);

        cyc(1, 0, 6'h3f);
        chk("ill_flag", int'(illegal_op), 1);
        chk("ill_nostrobe", int'({regwrite, pcwrite}), 0);
        cyc(1, 0, 6'h3f);
        chk("ill_fetch", int'(state_o), 1);
        chk("ill_clear", int'(illegal_op), 0);

        cyc(1, 0, 6'h00);
        cyc(1, 0, 6'h00);
        chk("mid_exec", int'(state_o), 7);
        #2 rst_n = 1'b0;
        ms = 0;
        path.delete();
        #1 chk("async_state", int'(state_o), 0);
        chk("async_outs", int'(dut_v), 0);
        cyc(1, 0, 6'h00);
        rst_n = 1'b1;
        chk("hold_idle", int'(state_o), 0);
        cyc(1, 0, 6'h00);
        chk("refetch", int'(state_o), 1);
        chk("refetch_ctl", int'({mem_req, alusrcb}), 'b101);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            step();
            #2 mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom_range(0, 1));
            if (ms != 3)
                opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                ms = 0;
                path.delete();
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS main control FSM. Decodes the instruction opcode and sequences the datapath over several cycles.
- Drives the 2-bit aluop consumed by the ALU decoder: 00 = add, 01 = sub (branch compare), 10 = use funct field.
- Sits between the instruction register and the datapath.
- Has a simple ready handshake to memory so instruction fetch and data accesses can stall.

Parameters:
- OPW, 6, opcode width.
- STW, 4, width of the state debug output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- memwrite  out  1  write strobe, valid with mem_req.
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- irwrite  out  1  load the instruction register.
- pcwrite  out  1  unconditional PC update.
- pcen  out  1  pcwrite OR (branch AND zero).
- branch  out  1  branch state active.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = data register, 0 = ALUOut.
- regwrite  out  1  register file write.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  out  2  to the ALU decoder.
- illegal_op  out  1  unrecognised opcode flag.
- state_o  out  STW  current state (debug).

Behaviour:
- Clocking and outputs:
  - State register only, updated on posedge clk.
  - All outputs are combinational functions of state (plus mem_ready/opcode where noted).
  - Any output not listed for a state is 0.
- Reset:
  - rst_n low forces state = IDLE immediately; every output is 0 while in IDLE.
  - IDLE always moves to FETCH on the next clock.
  - Reset mid-instruction abandons it; no strobe may be asserted in the cycle after rst_n falls.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States, outputs and transitions (encodings fixed, 4 bits):
  - IDLE (0): all outputs 0 -> FETCH.
  - FETCH (1): mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Hold while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE (2): alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEXEC
    - j -> JUMP
    - other -> FETCH with illegal_op=1 for this cycle only.
  - MEMADR (3): alusrca=1, alusrcb=10, aluop=00 -> MEMRD (lw) or MEMWR (sw).
  - MEMRD (4): mem_req=1, iord=1; hold until mem_ready -> MEMWB.
  - MEMWB (5): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR (6): mem_req=1, iord=1, memwrite=1; hold until mem_ready -> FETCH.
  - EXECUTE (7): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB (8): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BRANCH (9): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEXEC (10): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB (11): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP (12): pcsrc=10, pcwrite=1 -> FETCH.
- Unused encodings 13–15 -> FETCH with all outputs 0.
- Handshake:
  - mem_req stays high and controls stay stable until mem_ready is sampled high.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- opcode is sampled only in DECODE and MEMADR.
- Latency in cycles with mem_ready tied high:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3

Decomposition:
- Package mips_ctrl_pkg:
  - state enum (4-bit, values above)
  - opcode localparams
  - aluop constants ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT
  - alusrcb and pcsrc encodings
- One natural sub-module: mips_ctrl_outdec, combinational state -> control-word decoder. The top holds the state register and next-state logic.

Test Plan:
- Reset and release: rst_n low mid-EXECUTE -> state_o=0 and all outputs 0 at once; release -> IDLE, then FETCH with mem_req=1, alusrcb=01.
- lw, opcode=100011, mem_ready=1 -> state sequence 1,2,3,4,5,1; MEMWB has regwrite=1, memtoreg=1, regdst=0.
- R-type, opcode=000000 -> EXECUTE has aluop=10; ALUWB has regdst=1, regwrite=1; total 4 cycles.
- beq with zero=1 then zero=0 -> BRANCH has aluop=01, pcsrc=01; pcen=1 only when zero=1.
- Stall: sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1, iord=1 held 4 cycles; FETCH follows the cycle after mem_ready=1.
- Illegal opcode 111111 -> illegal_op=1 for exactly one DECODE cycle, no regwrite or pcwrite, next state FETCH.
